// File: rtl/decode_hazard_ctrl.sv
// decode_hazard_ctrl: ID-stage hazard and stall controller for a 5-stage RISC-V pipe.
// It detects load-use and multi-cycle M-extension hazards, and handles branch flushes.
// Stall and flush decisions are combinational, so they take effect in the same cycle.
// Build option: define DECODE_HAZARD_FORWARD_EN when the full forwarding network exists.
// Without that macro, RAW hazards against EX, MEM and WB also stall.
module decode_hazard_ctrl #(
    parameter int unsigned MULDIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [6:0] id_funct7,
    input  logic [4:0] id_rs1_addr,
    input  logic [4:0] id_rs2_addr,
    input  logic       ex_valid,
    input  logic [6:0] ex_opcode,
    input  logic [4:0] ex_rd_addr,
    input  logic       br_taken,
    input  logic       mem_valid,
    input  logic       mem_wr_en,
    input  logic [4:0] mem_rd_addr,
    input  logic       wb_valid,
    input  logic       wb_wr_en,
    input  logic [4:0] wb_rd_addr,
    output logic       stall_if,
    output logic       stall_id,
    output logic       flush_id,
    output logic       flush_ex,
    output logic       md_busy
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] FUNCT7_MD  = 7'b0000001;

    // The first MD_BUSY cycle and the RUN cycle that issues the stall are both counted.
    localparam logic [7:0] CNT_LOAD = 8'(MULDIV_LAT - 2);

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       mdOk_q, mdOk_d;

    logic rs1Used;
    logic rs2Used;
    logic loadUse;
    logic mulDiv;
    logic rawHazard;
    logic dataStall;

    // True when a used, nonzero ID source register matches the given destination.
    function automatic logic srcMatch(input logic [4:0] rdAddr,
                                      input logic [4:0] rs1Addr,
                                      input logic [4:0] rs2Addr,
                                      input logic       rs1Use,
                                      input logic       rs2Use);
        return (rs1Use && (rs1Addr != 5'd0) && (rs1Addr == rdAddr)) ||
               (rs2Use && (rs2Addr != 5'd0) && (rs2Addr == rdAddr));
    endfunction

    assign rs1Used = (id_opcode == OPC_OP)    || (id_opcode == OPC_OP_IMM) ||
                     (id_opcode == OPC_LOAD)  || (id_opcode == OPC_STORE)  ||
                     (id_opcode == OPC_BRANCH) || (id_opcode == OPC_JALR);
    assign rs2Used = (id_opcode == OPC_OP) || (id_opcode == OPC_STORE) ||
                     (id_opcode == OPC_BRANCH);

    assign loadUse = id_valid && ex_valid && (ex_opcode == OPC_LOAD) &&
                     srcMatch(ex_rd_addr, id_rs1_addr, id_rs2_addr, rs1Used, rs2Used);

    assign mulDiv = id_valid && (id_opcode == OPC_OP) && (id_funct7 == FUNCT7_MD);

`ifdef DECODE_HAZARD_FORWARD_EN
    assign rawHazard = 1'b0;
`else
    assign rawHazard = id_valid && (
        (ex_valid && (ex_opcode != OPC_STORE) && (ex_opcode != OPC_BRANCH) &&
         srcMatch(ex_rd_addr, id_rs1_addr, id_rs2_addr, rs1Used, rs2Used)) ||
        (mem_valid && mem_wr_en &&
         srcMatch(mem_rd_addr, id_rs1_addr, id_rs2_addr, rs1Used, rs2Used)) ||
        (wb_valid && wb_wr_en &&
         srcMatch(wb_rd_addr, id_rs1_addr, id_rs2_addr, rs1Used, rs2Used)));
`endif

    assign dataStall = loadUse || rawHazard;

    // Next-state and output decode: branch flush wins, then data stalls, then mul/div.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mdOk_d   = mdOk_q;
        stall_if = 1'b0;
        stall_id = 1'b0;
        flush_id = 1'b0;
        flush_ex = 1'b0;
        md_busy  = 1'b0;

        if (br_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            state_d  = RUN;
            cnt_d    = 8'd0;
            mdOk_d   = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (dataStall) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end else if (mulDiv && !mdOk_q) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                        cnt_d    = CNT_LOAD;
                        state_d  = MD_BUSY;
                    end else begin
                        mdOk_d = 1'b0;
                    end
                end
                MD_BUSY: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    flush_ex = 1'b1;
                    md_busy  = 1'b1;
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        state_d = RUN;
                        mdOk_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end

        if (!rst_n) begin
            stall_if = 1'b0;
            stall_id = 1'b0;
            flush_id = 1'b0;
            flush_ex = 1'b0;
            md_busy  = 1'b0;
        end
    end

    // State, counter and mul/div-done flag, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= 8'd0;
            mdOk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mdOk_q  <= mdOk_d;
        end
    end

endmodule

// File: tb/tb_decode_hazard_ctrl.sv
// tb_decode_hazard_ctrl: directed scoreboard bench for decode_hazard_ctrl (MULDIV_LAT=4).
// Each stimulus vector pushes its expected output pattern into a queue.
// A negedge monitor pops one entry per cycle and compares it with the DUT outputs.
// Output pattern bit order: {stall_if, stall_id, flush_id, flush_ex, md_busy}.
module tb_decode_hazard_ctrl;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] F7_MD  = 7'b0000001;

    localparam logic [4:0] E_NONE  = 5'b00000;
    localparam logic [4:0] E_STALL = 5'b11010;
    localparam logic [4:0] E_MDB   = 5'b11011;
    localparam logic [4:0] E_FLUSH = 5'b00110;

`ifdef DECODE_HAZARD_FORWARD_EN
    localparam logic [4:0] E_RAW = E_NONE;
`else
    localparam logic [4:0] E_RAW = E_STALL;
`endif

    typedef struct {
        logic       rstN;
        logic       idValid;
        logic [6:0] idOp;
        logic [6:0] idF7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       exValid;
        logic [6:0] exOp;
        logic [4:0] exRd;
        logic       br;
        logic       memValid;
        logic       memWr;
        logic [4:0] memRd;
        logic       wbValid;
        logic       wbWr;
        logic [4:0] wbRd;
    } stim_t;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [6:0] id_funct7;
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       ex_valid;
    logic [6:0] ex_opcode;
    logic [4:0] ex_rd_addr;
    logic       br_taken;
    logic       mem_valid;
    logic       mem_wr_en;
    logic [4:0] mem_rd_addr;
    logic       wb_valid;
    logic       wb_wr_en;
    logic [4:0] wb_rd_addr;
    logic       stall_if;
    logic       stall_id;
    logic       flush_id;
    logic       flush_ex;
    logic       md_busy;

    logic [4:0] expQ[$];
    string      nameQ[$];
    int         vectorsApplied = 0;
    int         miscompares    = 0;

    decode_hazard_ctrl #(.MULDIV_LAT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_opcode  (id_opcode),
        .id_funct7  (id_funct7),
        .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr),
        .ex_valid   (ex_valid),
        .ex_opcode  (ex_opcode),
        .ex_rd_addr (ex_rd_addr),
        .br_taken   (br_taken),
        .mem_valid  (mem_valid),
        .mem_wr_en  (mem_wr_en),
        .mem_rd_addr(mem_rd_addr),
        .wb_valid   (wb_valid),
        .wb_wr_en   (wb_wr_en),
        .wb_rd_addr (wb_rd_addr),
        .stall_if   (stall_if),
        .stall_id   (stall_id),
        .flush_id   (flush_id),
        .flush_ex   (flush_ex),
        .md_busy    (md_busy)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // An idle pipeline slot with reset released.
    function automatic stim_t idle();
        stim_t s;
        s.rstN = 1'b1; s.idValid = 1'b0; s.idOp = 7'd0; s.idF7 = 7'd0;
        s.rs1 = 5'd0; s.rs2 = 5'd0; s.exValid = 1'b0; s.exOp = 7'd0;
        s.exRd = 5'd0; s.br = 1'b0; s.memValid = 1'b0; s.memWr = 1'b0;
        s.memRd = 5'd0; s.wbValid = 1'b0; s.wbWr = 1'b0; s.wbRd = 5'd0;
        return s;
    endfunction

    // ID holds an R-type instruction; funct7 selects plain ALU or M-extension.
    function automatic stim_t idR(input logic [6:0] f7, input logic [4:0] a, input logic [4:0] b);
        stim_t s;
        s = idle();
        s.idValid = 1'b1; s.idOp = OP_R; s.idF7 = f7; s.rs1 = a; s.rs2 = b;
        return s;
    endfunction

    task automatic applyStimulus(input stim_t s, input logic [4:0] expected, input string name);
        @(posedge clk);
        #1;
        rst_n = s.rstN; id_valid = s.idValid; id_opcode = s.idOp; id_funct7 = s.idF7;
        id_rs1_addr = s.rs1; id_rs2_addr = s.rs2; ex_valid = s.exValid;
        ex_opcode = s.exOp; ex_rd_addr = s.exRd; br_taken = s.br;
        mem_valid = s.memValid; mem_wr_en = s.memWr; mem_rd_addr = s.memRd;
        wb_valid = s.wbValid; wb_wr_en = s.wbWr; wb_rd_addr = s.wbRd;
        expQ.push_back(expected);
        nameQ.push_back(name);
    endtask

    task automatic checkOutput(input logic [4:0] expected, input string name);
        logic [4:0] actual;
        actual = {stall_if, stall_id, flush_id, flush_ex, md_busy};
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, expected %b (stall_if,stall_id,flush_id,flush_ex,md_busy)",
                     name, actual, expected);
        end
    endtask

    // Monitor: compares one scoreboard entry per cycle, mid-cycle.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front(), nameQ.pop_front());
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0; id_valid = 1'b0; id_opcode = 7'd0; id_funct7 = 7'd0;
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_valid = 1'b0; ex_opcode = 7'd0;
        ex_rd_addr = 5'd0; br_taken = 1'b0; mem_valid = 1'b0; mem_wr_en = 1'b0;
        mem_rd_addr = 5'd0; wb_valid = 1'b0; wb_wr_en = 1'b0; wb_rd_addr = 5'd0;

        // Reset forces all outputs low even with branch and mul/div presented.
        s = idR(F7_MD, 5'd1, 5'd2); s.rstN = 1'b0; s.br = 1'b1;
        applyStimulus(s, E_NONE, "reset_br_mul");
        s = idR(F7_MD, 5'd1, 5'd2); s.rstN = 1'b0;
        applyStimulus(s, E_NONE, "reset_mul");
        applyStimulus(idle(), E_NONE, "idle");

        // Load-use: EX lw x5, ID add x6,x5,x7.
        s = idR(7'd0, 5'd5, 5'd7); s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd5;
        applyStimulus(s, E_STALL, "load_use");
        applyStimulus(idR(7'd0, 5'd5, 5'd7), E_NONE, "load_use_release");

        // Load to x0 never stalls.
        s = idR(7'd0, 5'd0, 5'd0); s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd0;
        applyStimulus(s, E_NONE, "load_x0");

        // addi ignores its rs2 field.
        s = idle(); s.idValid = 1'b1; s.idOp = OP_I; s.rs1 = 5'd9; s.rs2 = 5'd5;
        s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd5;
        applyStimulus(s, E_NONE, "addi_rs2_unused");

        // Store uses rs2.
        s = idle(); s.idValid = 1'b1; s.idOp = OP_ST; s.rs1 = 5'd9; s.rs2 = 5'd5;
        s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd5;
        applyStimulus(s, E_STALL, "store_rs2_load_use");

        // Load-use ignored when ID slot is invalid.
        s = idR(7'd0, 5'd5, 5'd7); s.idValid = 1'b0; s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd5;
        applyStimulus(s, E_NONE, "load_use_id_invalid");

        // mul with MULDIV_LAT=4: four stall cycles, md_busy on cycles 2..4, no re-trigger.
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_STALL, "mul_c1");
        for (int i = 0; i < 3; i++) applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_MDB, "mul_busy");
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_NONE, "mul_no_retrigger");
        // A following mul starts a fresh sequence since md_ok has cleared.
        applyStimulus(idR(F7_MD, 5'd3, 5'd4), E_STALL, "mul2_c1");
        for (int i = 0; i < 3; i++) applyStimulus(idR(F7_MD, 5'd3, 5'd4), E_MDB, "mul2_busy");
        applyStimulus(idR(F7_MD, 5'd3, 5'd4), E_NONE, "mul2_release");
        applyStimulus(idle(), E_NONE, "idle2");

        // Branch taken in the second stall cycle aborts the sequence.
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_STALL, "mulbr_c1");
        s = idR(F7_MD, 5'd1, 5'd2); s.br = 1'b1;
        applyStimulus(s, E_FLUSH, "mulbr_flush");
        applyStimulus(idle(), E_NONE, "mulbr_after");

        // Reset during MD_BUSY: outputs drop at once, sequence restarts from RUN.
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_STALL, "mulrst_c1");
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_MDB, "mulrst_c2");
        s = idR(F7_MD, 5'd1, 5'd2); s.rstN = 1'b0;
        applyStimulus(s, E_NONE, "mulrst_reset");
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_STALL, "mulrst_restart");
        s = idle(); s.br = 1'b1;
        applyStimulus(s, E_FLUSH, "mulrst_clear");

        // Load-use and mul together: one load-use stall, then the full mul sequence.
        s = idR(F7_MD, 5'd1, 5'd2); s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd1;
        applyStimulus(s, E_STALL, "lu_mul_lu");
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_STALL, "lu_mul_c1");
        for (int i = 0; i < 3; i++) applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_MDB, "lu_mul_busy");
        applyStimulus(idR(F7_MD, 5'd1, 5'd2), E_NONE, "lu_mul_release");

        // RAW against WB, MEM and EX writers (stall only without forwarding).
        s = idR(7'd0, 5'd4, 5'd3); s.wbValid = 1'b1; s.wbWr = 1'b1; s.wbRd = 5'd3;
        applyStimulus(s, E_RAW, "raw_wb_rs2");
        s = idR(7'd0, 5'd4, 5'd3); s.wbValid = 1'b1; s.wbWr = 1'b0; s.wbRd = 5'd3;
        applyStimulus(s, E_NONE, "raw_wb_no_wr");
        s = idR(7'd0, 5'd6, 5'd4); s.memValid = 1'b1; s.memWr = 1'b1; s.memRd = 5'd6;
        applyStimulus(s, E_RAW, "raw_mem_rs1");
        s = idR(7'd0, 5'd8, 5'd4); s.exValid = 1'b1; s.exOp = OP_I; s.exRd = 5'd8;
        applyStimulus(s, E_RAW, "raw_ex_addi");
        s = idR(7'd0, 5'd8, 5'd4); s.exValid = 1'b1; s.exOp = OP_ST; s.exRd = 5'd8;
        applyStimulus(s, E_NONE, "raw_ex_store");

        // Branch beats a simultaneous load-use.
        s = idR(7'd0, 5'd5, 5'd7); s.exValid = 1'b1; s.exOp = OP_LD; s.exRd = 5'd5; s.br = 1'b1;
        applyStimulus(s, E_FLUSH, "br_over_load_use");
        applyStimulus(idle(), E_NONE, "final_idle");

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule

// File: doc/decode_hazard_ctrl.md
DECODE_HAZARD_CTRL -- requirements
Module: decode_hazard_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 32, giving the number of ID stall cycles per M-extension instruction; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-004 SHALL have ID-stage inputs: id_valid 1b, id_opcode 7b, id_funct7 7b, id_rs1_addr 5b, id_rs2_addr 5b, all fields decoded from the ID instruction word.
REQ-005 SHALL have EX-stage inputs: ex_valid 1b, ex_opcode 7b, ex_rd_addr 5b, br_taken 1b (branch/jump resolved taken in EX).
REQ-006 SHALL have MEM/WB inputs: mem_valid 1b, mem_wr_en 1b, mem_rd_addr 5b, wb_valid 1b, wb_wr_en 1b, wb_rd_addr 5b.
REQ-007 SHALL have outputs, all 1b: stall_if (hold PC), stall_id (hold IF/ID register), flush_id (invalidate IF/ID), flush_ex (insert bubble into ID/EX), md_busy (multi-cycle stall in progress).

Function
REQ-008 SHALL treat rs1 as used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, and rs2 as used for 0110011, 0100011, 1100011; address x0 never creates a hazard.
REQ-009 SHALL flag load_use when id_valid, ex_valid, ex_opcode==0000011, ex_rd_addr!=0 and ex_rd_addr equals a used ID source address.
REQ-010 SHALL flag muldiv when id_valid, id_opcode==0110011 and id_funct7==0000001.
REQ-011 SHALL implement a two-state FSM, RUN and MD_BUSY, plus an 8-bit down-counter cnt and a flag md_ok.
REQ-012 SHALL drive all outputs combinationally from FSM state, cnt, md_ok and the current inputs (zero-latency stall decision).
REQ-013 SHALL give br_taken top priority in any state: flush_id=1, flush_ex=1, stall_if=0, stall_id=0; next state RUN, cnt=0, md_ok=0.
REQ-014 SHALL, in RUN with load_use and no br_taken, assert stall_if, stall_id and flush_ex for exactly one cycle.
REQ-015 SHALL, in RUN with muldiv, md_ok=0, no load_use and no br_taken, assert stall_if, stall_id and flush_ex, load cnt=MULDIV_LAT-2, and go to MD_BUSY.
REQ-016 SHALL, in MD_BUSY, assert stall_if, stall_id, flush_ex and md_busy each cycle; when cnt!=0, decrement cnt; when cnt==0, return to RUN and set md_ok=1. Total stall is exactly MULDIV_LAT cycles.
REQ-017 SHALL, in RUN with md_ok=1, not re-trigger on the held muldiv instruction; md_ok clears in the first cycle in which stall_id=0.
REQ-018 SHALL, when load_use and muldiv coincide, serve load_use first (one stall cycle), then start the muldiv sequence.
REQ-019 SHALL keep flush_id=0 except on br_taken.

Reset
REQ-020 SHALL, on a clk edge with rst_n=0, set state=RUN, cnt=0 and md_ok=0, including in the middle of an MD_BUSY sequence.
REQ-021 SHALL force every output to 0 while rst_n=0, regardless of other inputs.

Configuration
REQ-022 SHALL use macro DECODE_HAZARD_FORWARD_EN; when it is defined, the full forwarding network exists and only load_use and muldiv stall.
REQ-023 SHALL, when DECODE_HAZARD_FORWARD_EN is undefined, additionally stall one cycle at a time (stall_if, stall_id, flush_ex) on RAW hazards. A RAW hazard is a used ID source address, nonzero, that matches any of: ex_rd_addr where ex_valid and ex_opcode writes rd (all except 0100011 and 1100011); mem_rd_addr where mem_valid and mem_wr_en; wb_rd_addr where wb_valid and wb_wr_en. Priority is the same as load_use.

Verification
REQ-024 SHALL cover load-use: EX lw x5 (ex_opcode 0000011, rd 5), ID add x6,x5,x7 -> one cycle of stall_if=stall_id=flush_ex=1, then all 0.
REQ-025 SHALL cover x0: EX lw x0, ID add x1,x0,x0 -> no stall.
REQ-026 SHALL cover muldiv: MULDIV_LAT=4, ID mul (funct7 0000001) -> stall high for exactly 4 cycles with md_busy high on cycles 2-4, then ID advances with no re-trigger.
REQ-027 SHALL cover a mid-muldiv branch: br_taken in 2nd stall cycle -> flush_id=flush_ex=1, stalls 0, md_busy 0 the next cycle.
REQ-028 SHALL cover mid-sequence reset: rst_n=0 during MD_BUSY -> all outputs 0 immediately, state RUN after the edge.
REQ-029 SHALL cover no forwarding: without DECODE_HAZARD_FORWARD_EN, WB writes x3 with wb_wr_en=1 and ID uses rs2=x3 -> one stall cycle; with the macro -> none.
